// File: rtl/text_console_controller.sv
// text_console_controller
//   Sequences writes into the character plane of a ROW_NUMBER x COL_NUMBER
//   text display. Characters arrive over a valid/ready handshake; the cursor
//   is tracked here, and control codes (LF, CR, BS) plus a whole-screen clear
//   request are turned into cell-write sequences, one cell per clock.
// Ports
//   clk, reset            clock (posedge) and synchronous active-high reset
//   char_in, char_valid   incoming character code and its valid flag
//   char_ready            combinational: IDLE and no clear request pending
//   clear_req             level request to blank the screen and home the cursor
//   wr_en/row/col/char    registered write port of the character plane
//   cursor_row/col        current cursor position
//   busy                  controller is running a line or screen clear
module text_console_controller #(
  parameter int unsigned                ROW_NUMBER     = 15,
  parameter int unsigned                COL_NUMBER     = 40,
  parameter int unsigned                CHAR_ID_LENGTH = 8,
  parameter int unsigned                ROW_BIT_LEN    = 4,
  parameter int unsigned                COL_BIT_LEN    = 6,
  parameter logic [CHAR_ID_LENGTH-1:0]  BLANK_CHAR     = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHAR_ID_LENGTH-1:0] char_in,
  input  logic                      char_valid,
  output logic                      char_ready,
  input  logic                      clear_req,
  output logic                      wr_en,
  output logic [ROW_BIT_LEN-1:0]    wr_row,
  output logic [COL_BIT_LEN-1:0]    wr_col,
  output logic [CHAR_ID_LENGTH-1:0] wr_char,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_CLEAR_LINE = 2'd1;
  localparam logic [1:0] S_CLEAR_ALL  = 2'd2;

  localparam logic [ROW_BIT_LEN-1:0]    ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]    COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [ROW_BIT_LEN-1:0]    ROW_ONE  = ROW_BIT_LEN'(1);
  localparam logic [COL_BIT_LEN-1:0]    COL_ONE  = COL_BIT_LEN'(1);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_LF    = CHAR_ID_LENGTH'(8'h0A);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_CR    = CHAR_ID_LENGTH'(8'h0D);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_BS    = CHAR_ID_LENGTH'(8'h08);

  logic [1:0]                r_state;
  logic [ROW_BIT_LEN-1:0]    r_clr_row;
  logic [COL_BIT_LEN-1:0]    r_clr_col;
  logic [ROW_BIT_LEN-1:0]    r_cur_row;
  logic [COL_BIT_LEN-1:0]    r_cur_col;
  logic                      r_wr_en;
  logic [ROW_BIT_LEN-1:0]    r_wr_row;
  logic [COL_BIT_LEN-1:0]    r_wr_col;
  logic [CHAR_ID_LENGTH-1:0] r_wr_char;

  logic                      w_accept;
  logic [ROW_BIT_LEN-1:0]    w_row_next;

  assign char_ready = (r_state == S_IDLE) && !clear_req;
  assign w_accept   = char_valid && char_ready;
  // Row advance wraps explicitly at the last text row, never at the binary limit.
  assign w_row_next = (r_cur_row == ROW_LAST) ? '0 : r_cur_row + ROW_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR_ALL;
      r_clr_row <= '0;
      r_clr_col <= '0;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_wr_en   <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_char <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state   <= S_CLEAR_ALL;
            r_clr_row <= '0;
            r_clr_col <= '0;
            r_cur_row <= '0;
            r_cur_col <= '0;
          end else if (w_accept) begin
            case (char_in)
              CH_LF: begin
                r_cur_col <= '0;
                r_cur_row <= w_row_next;
                r_clr_col <= '0;
                r_state   <= S_CLEAR_LINE;
              end
              CH_CR: begin
                r_cur_col <= '0;
              end
              CH_BS: begin
                if (r_cur_col != '0) begin
                  r_cur_col <= r_cur_col - COL_ONE;
                  r_wr_en   <= 1'b1;
                  r_wr_row  <= r_cur_row;
                  r_wr_col  <= r_cur_col - COL_ONE;
                  r_wr_char <= BLANK_CHAR;
                end else if (r_cur_row != '0) begin
                  r_cur_row <= r_cur_row - ROW_ONE;
                  r_cur_col <= COL_LAST;
                  r_wr_en   <= 1'b1;
                  r_wr_row  <= r_cur_row - ROW_ONE;
                  r_wr_col  <= COL_LAST;
                  r_wr_char <= BLANK_CHAR;
                end
              end
              default: begin
                r_wr_en   <= 1'b1;
                r_wr_row  <= r_cur_row;
                r_wr_col  <= r_cur_col;
                r_wr_char <= char_in;
                if (r_cur_col == COL_LAST) begin
                  r_cur_col <= '0;
                  r_cur_row <= w_row_next;
                  r_clr_col <= '0;
                  r_state   <= S_CLEAR_LINE;
                end else begin
                  r_cur_col <= r_cur_col + COL_ONE;
                end
              end
            endcase
          end
        end
        S_CLEAR_LINE: begin
          // Cursor already sits at column 0 of the line being blanked.
          r_wr_en   <= 1'b1;
          r_wr_row  <= r_cur_row;
          r_wr_col  <= r_clr_col;
          r_wr_char <= BLANK_CHAR;
          if (r_clr_col == COL_LAST) begin
            r_clr_col <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clr_col <= r_clr_col + COL_ONE;
          end
        end
        S_CLEAR_ALL: begin
          r_wr_en   <= 1'b1;
          r_wr_row  <= r_clr_row;
          r_wr_col  <= r_clr_col;
          r_wr_char <= BLANK_CHAR;
          if (r_clr_col == COL_LAST) begin
            r_clr_col <= '0;
            if (r_clr_row == ROW_LAST) begin
              r_clr_row <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_clr_row <= r_clr_row + ROW_ONE;
            end
          end else begin
            r_clr_col <= r_clr_col + COL_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_row     = r_wr_row;
  assign wr_col     = r_wr_col;
  assign wr_char    = r_wr_char;
  assign cursor_row = r_cur_row;
  assign cursor_col = r_cur_col;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_text_console_controller.sv
// Testbench for text_console_controller: expected cell writes are pushed into
// a scoreboard queue by a screen-level model; a monitor pops and compares
// every wr_en pulse on the falling clock edge.
module tb_text_console_controller;

  localparam int ROWS  = 15;
  localparam int COLS  = 40;
  localparam int BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       clear_req = 1'b0;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_char;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  text_console_controller #(
    .ROW_NUMBER(15), .COL_NUMBER(40), .CHAR_ID_LENGTH(8),
    .ROW_BIT_LEN(4), .COL_BIT_LEN(6), .BLANK_CHAR(8'h20)
  ) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .clear_req(clear_req), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int q[$];        // expected writes, packed as row*65536 + col*256 + char
  int mrow = 0;
  int mcol = 0;

  function automatic int pk(int r, int c, int ch);
    return r * 65536 + c * 256 + ch;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  // Screen-level reference model.
  function automatic void push_line(int r);
    for (int c = 0; c < COLS; c++) q.push_back(pk(r, c, BLANK));
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++) push_line(r);
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void model_char(int ch);
    if (ch == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      push_line(mrow);
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        q.push_back(pk(mrow, mcol, BLANK));
      end else if (mrow > 0) begin
        mrow--;
        mcol = COLS - 1;
        q.push_back(pk(mrow, mcol, BLANK));
      end
    end else begin
      q.push_back(pk(mrow, mcol, ch));
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_line(mrow);
      end
    end
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=none at %0t",
                   pk(int'(wr_row), int'(wr_col), int'(wr_char)), $time);
        end else begin
          chk("write_cell", pk(int'(wr_row), int'(wr_col), int'(wr_char)), q.pop_front());
        end
      end
    end
  end

  // Driver steps happen just after the falling edge, after the monitor.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send(int ch);
    int n = 0;
    char_in = 8'(ch);
    char_valid = 1'b1;
    while (!char_ready && n < 2000) begin
      cyc();
      n++;
    end
    if (!char_ready) begin
      timeout_fail("send_ready");
      char_valid = 1'b0;
      return;
    end
    model_char(ch);
    cyc();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 3000) begin
      cyc();
      n++;
    end
    if (busy || q.size() != 0) timeout_fail("wait_idle");
  endtask

  task automatic check_cursor(string tag, int r, int c);
    chk({tag, "_row"}, int'(cursor_row), r);
    chk({tag, "_col"}, int'(cursor_col), c);
  endtask

  task automatic do_clear(bit with_char);
    wait_idle();
    clear_req = 1'b1;
    char_valid = with_char;
    char_in = 8'h41;
    #1;
    chk("ready_under_clear_req", int'(char_ready), 0);
    model_clear();
    cyc();
    clear_req = 1'b0;
    char_valid = 1'b0;
  endtask

  // Counts a full-screen clear already underway (first pulse on the next edge).
  task automatic expect_full_clear(string tag);
    int n = 0;
    int pulses = 0;
    do begin
      cyc();
      n++;
      if (wr_en) pulses++;
    end while (busy && n < 700);
    chk({tag, "_cycles"}, n, ROWS * COLS);
    chk({tag, "_pulses"}, pulses, ROWS * COLS);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int k;
    int pulses;
    int r;

    // 1: reset state, then the power-on clear
    model_clear();
    cyc();
    cyc();
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_row", int'(wr_row), 0);
    chk("rst_wr_col", int'(wr_col), 0);
    chk("rst_wr_char", int'(wr_char), 0);
    chk("rst_busy", int'(busy), 1);
    check_cursor("rst_cursor", 0, 0);
    reset = 1'b0;
    expect_full_clear("init_clear");
    check_cursor("init_cursor", 0, 0);

    // 2: back-to-back printable characters
    char_valid = 1'b1;
    char_in = 8'h41;
    chk("bb_ready", int'(char_ready), 1);
    model_char(8'h41);
    cyc();
    chk("bb_first", pk(int'(wr_en), 0, 0) + pk(int'(wr_row), int'(wr_col), int'(wr_char)),
        pk(1, 0, 0) + pk(0, 0, 8'h41));
    char_in = 8'h42;
    model_char(8'h42);
    cyc();
    chk("bb_second", pk(int'(wr_en), 0, 0) + pk(int'(wr_row), int'(wr_col), int'(wr_char)),
        pk(1, 0, 0) + pk(0, 1, 8'h42));
    char_valid = 1'b0;
    cyc();
    check_cursor("bb_cursor", 0, 2);

    // 3: fill a row, line clear of row 1 with ready held low
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(int'($urandom_range(8'h21, 8'h7e)));
    k = 0;
    while (!char_ready && k < 100) begin
      k++;
      cyc();
    end
    chk("line_clear_notready_cycles", k, COLS);
    wait_idle();
    check_cursor("wrap_cursor", 1, 0);

    // 4: LF from the bottom row wraps to row 0
    for (int i = 0; i < 13; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(int'($urandom_range(8'h21, 8'h7e)));
    wait_idle();
    check_cursor("pre_lf_cursor", 14, 5);
    send(8'h0A);
    wait_idle();
    check_cursor("lf_wrap_cursor", 0, 0);

    // 5: backspace across a row boundary, and at home
    send(8'h0A);
    send(8'h0A);
    send(8'h0A);
    wait_idle();
    check_cursor("pre_bs_cursor", 3, 0);
    send(8'h08);
    wait_idle();
    check_cursor("bs_cursor", 2, 39);
    do_clear(1'b0);
    expect_full_clear("plain_clear");
    send(8'h08);
    chk("bs_home_no_write", int'(wr_en), 0);
    cyc();
    check_cursor("bs_home_cursor", 0, 0);

    // 6: clear request beats a valid char; reset mid-clear restarts it
    send(8'h43);
    wait_idle();
    do_clear(1'b1);
    pulses = 0;
    k = 0;
    while (pulses < 100 && k < 200) begin
      cyc();
      k++;
      if (wr_en) pulses++;
    end
    chk("pulses_before_reset", pulses, 100);
    q.delete();
    model_clear();
    reset = 1'b1;
    cyc();
    cyc();
    chk("midreset_wr_en", int'(wr_en), 0);
    check_cursor("midreset_cursor", 0, 0);
    reset = 1'b0;
    expect_full_clear("restart_clear");

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_clear(1'b0);
      end else if (r < 13) begin
        send(8'h0A);
      end else if (r < 20) begin
        send(8'h0D);
      end else if (r < 32) begin
        send(8'h08);
      end else begin
        send(int'($urandom_range(8'h20, 8'hff)) == 8'h0A ? 8'h41 : int'($urandom_range(8'h20, 8'hff)));
      end
      if (i % 25 == 24) begin
        wait_idle();
        check_cursor("rand_cursor", mrow, mcol);
      end
    end

    wait_idle();
    cyc();
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
